pipe_hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 54-instruction static pipeline CPU. It drives the write enables and bubble request into the PC, IF/ID and ID/EXE pipeline registers. It resolves two hazards: load-use (by inserting one bubble into EXE) and multi-cycle divide (by freezing the front of the pipeline until the divider finishes). It sits beside the ID stage and consumes ID operand addresses plus the EXE-stage control fields held by the ID/EXE register.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 28 ++
 rtl/pipe_hazard_ctrl_luh.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: pipeline-register
// control levels, the active reset level, FSM state encodings and a
// saturating counter helper.
`ifndef PIPE_HAZARD_CTRL_DEFS
`define PIPE_HAZARD_CTRL_DEFS
`define STOP          1'b1
`define WRITE_ENABLED 1'b1
`define RST_ENABLED   1'b0
`endif

package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_BUSY = 2'd1,
        MUL_BUSY = 2'd2
    } hz_state_e;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_luh.sv
// Load-use comparator: flags an ID instruction that reads the destination
// of a load currently in EXE. Writes to $0 never create a dependency.
module pipe_luh_detect (
    input  logic [4:0] id_rs_raddr,
    input  logic [4:0] id_rt_raddr,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic [4:0] exe_rf_waddr,
    input  logic       exe_rf_wena,
    input  logic       exe_mem_read,
    output logic       luh
);

    logic rs_hit_s;
    logic rt_hit_s;

    assign rs_hit_s = id_rs_used & (id_rs_raddr == exe_rf_waddr);
    assign rt_hit_s = id_rt_used & (id_rt_raddr == exe_rf_waddr);
    assign luh      = exe_mem_read & exe_rf_wena & (exe_rf_waddr != 5'd0)
                    & (rs_hit_s | rt_hit_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and stall controller: inserts one bubble on load-use and
// freezes the front of the pipeline while a multi-cycle divide (and, when
// MUL_MULTICYCLE_EN is defined, multiply) occupies EXE. Outputs react in the
// same cycle as the hazard; reset forces them to the free-running values.
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs_raddr,
    input  logic [4:0]  id_rt_raddr,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic [4:0]  exe_rf_waddr,
    input  logic        exe_rf_wena,
    input  logic        exe_mem_read,
    input  logic        exe_div_ena,
    input  logic        exe_mul_ena,
    output logic        pc_wena,
    output logic        if_id_wena,
    output logic        id_exe_wena,
    output logic        stall,
    output logic        div_start,
    output logic        mul_start,
    output logic        busy,
    output logic [31:0] stall_cycles
);

    hz_state_e   state_r, state_nxt_s;
    logic [31:0] cnt_r, cnt_nxt_s;
    logic [31:0] stall_cycles_r;
    logic        luh_s;

    // Unreset view of the controls; rst is applied only at the ports so it
    // never feeds the data path of the registers it also resets.
    logic pc_wena_s, if_id_wena_s, id_exe_wena_s, stall_s;
    logic div_start_s, mul_start_s, busy_s;

`ifndef MUL_MULTICYCLE_EN
    // Single-cycle multiplier: the multiply request and its length are unused.
    logic                   mul_ena_unused_s;
    localparam int unsigned MUL_CYCLES_UNUSED = MUL_CYCLES;
    assign mul_ena_unused_s = exe_mul_ena;
`endif

    pipe_luh_detect u_luh (
        .id_rs_raddr  (id_rs_raddr),
        .id_rt_raddr  (id_rt_raddr),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .exe_rf_waddr (exe_rf_waddr),
        .exe_rf_wena  (exe_rf_wena),
        .exe_mem_read (exe_mem_read),
        .luh          (luh_s)
    );

    // Next-state and control decode; divide beats multiply beats load-use.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        pc_wena_s     = `WRITE_ENABLED;
        if_id_wena_s  = `WRITE_ENABLED;
        id_exe_wena_s = `WRITE_ENABLED;
        stall_s       = ~(`STOP);
        div_start_s   = 1'b0;
        mul_start_s   = 1'b0;
        busy_s        = 1'b0;
        case (state_r)
            RUN: begin
                if (exe_div_ena) begin
                    pc_wena_s     = ~(`WRITE_ENABLED);
                    if_id_wena_s  = ~(`WRITE_ENABLED);
                    id_exe_wena_s = ~(`WRITE_ENABLED);
                    div_start_s   = 1'b1;
                    busy_s        = 1'b1;
                    state_nxt_s   = DIV_BUSY;
                    cnt_nxt_s     = 32'd1;
`ifdef MUL_MULTICYCLE_EN
                end else if (exe_mul_ena) begin
                    pc_wena_s     = ~(`WRITE_ENABLED);
                    if_id_wena_s  = ~(`WRITE_ENABLED);
                    id_exe_wena_s = ~(`WRITE_ENABLED);
                    mul_start_s   = 1'b1;
                    busy_s        = 1'b1;
                    state_nxt_s   = MUL_BUSY;
                    cnt_nxt_s     = 32'd1;
`endif
                end else if (luh_s) begin
                    // One bubble: hold PC and IF/ID, load zeros into ID/EXE.
                    pc_wena_s     = ~(`WRITE_ENABLED);
                    if_id_wena_s  = ~(`WRITE_ENABLED);
                    stall_s       = `STOP;
                end else begin
                    state_nxt_s   = RUN;
                end
            end
            DIV_BUSY: begin
                if (cnt_r < (DIV_CYCLES - 32'd1)) begin
                    pc_wena_s     = ~(`WRITE_ENABLED);
                    if_id_wena_s  = ~(`WRITE_ENABLED);
                    id_exe_wena_s = ~(`WRITE_ENABLED);
                    busy_s        = 1'b1;
                    cnt_nxt_s     = cnt_r + 32'd1;
                end else begin
                    // Last occupancy cycle: the divide leaves EXE on this edge.
                    state_nxt_s   = RUN;
                    cnt_nxt_s     = 32'd0;
                end
            end
`ifdef MUL_MULTICYCLE_EN
            MUL_BUSY: begin
                if (cnt_r < (MUL_CYCLES - 32'd1)) begin
                    pc_wena_s     = ~(`WRITE_ENABLED);
                    if_id_wena_s  = ~(`WRITE_ENABLED);
                    id_exe_wena_s = ~(`WRITE_ENABLED);
                    busy_s        = 1'b1;
                    cnt_nxt_s     = cnt_r + 32'd1;
                end else begin
                    state_nxt_s   = RUN;
                    cnt_nxt_s     = 32'd0;
                end
            end
`endif
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = 32'd0;
            end
        endcase
    end

    // State, occupancy counter and saturating stall counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == `RST_ENABLED) begin
            state_r        <= RUN;
            cnt_r          <= 32'd0;
            stall_cycles_r <= 32'd0;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            if (pc_wena_s == `WRITE_ENABLED) begin
                stall_cycles_r <= stall_cycles_r;
            end else begin
                stall_cycles_r <= sat_inc32(stall_cycles_r);
            end
        end
    end

    // Port drive: reset forces the free-running control values immediately.
    always_comb begin
        if (rst == `RST_ENABLED) begin
            pc_wena     = `WRITE_ENABLED;
            if_id_wena  = `WRITE_ENABLED;
            id_exe_wena = `WRITE_ENABLED;
            stall       = ~(`STOP);
            div_start   = 1'b0;
            mul_start   = 1'b0;
            busy        = 1'b0;
        end else begin
            pc_wena     = pc_wena_s;
            if_id_wena  = if_id_wena_s;
            id_exe_wena = id_exe_wena_s;
            stall       = stall_s;
            div_start   = div_start_s;
            mul_start   = mul_start_s;
            busy        = busy_s;
        end
    end

    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle load-use
// vectors, hand-written divide/multiply/reset sequences, and a randomized run
// against an occupancy-countdown reference model.
module tb_pipe_hazard_ctrl;

    localparam int DIVC = 32;
    localparam int MULC = 4;
`ifdef MUL_MULTICYCLE_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    // {pc_wena, if_id_wena, id_exe_wena, stall, div_start, mul_start, busy}
    localparam logic [6:0] O_IDLE   = 7'b1110000;
    localparam logic [6:0] O_LUH    = 7'b0011000;
    localparam logic [6:0] O_DSTART = 7'b0000101;
    localparam logic [6:0] O_MSTART = 7'b0000011;
    localparam logic [6:0] O_FREEZE = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs_raddr = 5'd0, id_rt_raddr = 5'd0, exe_rf_waddr = 5'd0;
    logic        id_rs_used = 1'b0, id_rt_used = 1'b0;
    logic        exe_rf_wena = 1'b0, exe_mem_read = 1'b0;
    logic        exe_div_ena = 1'b0, exe_mul_ena = 1'b0;
    logic        pc_wena, if_id_wena, id_exe_wena, stall, div_start, mul_start, busy;
    logic [31:0] stall_cycles;
    logic [6:0]  outs;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign outs = {pc_wena, if_id_wena, id_exe_wena, stall, div_start, mul_start, busy};

    pipe_hazard_ctrl #(.DIV_CYCLES(DIVC), .MUL_CYCLES(MULC)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs_raddr  (id_rs_raddr),
        .id_rt_raddr  (id_rt_raddr),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .exe_rf_waddr (exe_rf_waddr),
        .exe_rf_wena  (exe_rf_wena),
        .exe_mem_read (exe_mem_read),
        .exe_div_ena  (exe_div_ena),
        .exe_mul_ena  (exe_mul_ena),
        .pc_wena      (pc_wena),
        .if_id_wena   (if_id_wena),
        .id_exe_wena  (id_exe_wena),
        .stall        (stall),
        .div_start    (div_start),
        .mul_start    (mul_start),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rsu;
        logic       rtu;
        logic [4:0] wa;
        logic       we;
        logic       mr;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_rs_raddr = 5'd0; id_rt_raddr = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        exe_rf_waddr = 5'd0; exe_rf_wena = 1'b0; exe_mem_read = 1'b0;
        exe_div_ena = 1'b0; exe_mul_ena = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int frozen, pulses, first_p, second_p, exp_sc, mfrozen, mpulses;
        int occ, kind, sc_model;
        logic [6:0] exp_o;
        logic luh_m;

        tbl[0] = '{5'd5,  5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b1, O_LUH};
        tbl[1] = '{5'd0,  5'd0, 1'b1, 1'b1, 5'd0,  1'b1, 1'b1, O_IDLE};
        tbl[2] = '{5'd5,  5'd5, 1'b0, 1'b0, 5'd5,  1'b1, 1'b1, O_IDLE};
        tbl[3] = '{5'd2,  5'd7, 1'b1, 1'b1, 5'd7,  1'b1, 1'b1, O_LUH};
        tbl[4] = '{5'd2,  5'd7, 1'b1, 1'b0, 5'd7,  1'b1, 1'b1, O_IDLE};
        tbl[5] = '{5'd9,  5'd9, 1'b1, 1'b1, 5'd9,  1'b1, 1'b0, O_IDLE};
        tbl[6] = '{5'd9,  5'd9, 1'b1, 1'b1, 5'd9,  1'b0, 1'b1, O_IDLE};
        tbl[7] = '{5'd31, 5'd31,1'b1, 1'b1, 5'd31, 1'b1, 1'b1, O_LUH};
        tbl[8] = '{5'd3,  5'd4, 1'b1, 1'b1, 5'd5,  1'b1, 1'b1, O_IDLE};
        tbl[9] = '{5'd5,  5'd5, 1'b1, 1'b0, 5'd5,  1'b1, 1'b1, O_LUH};

        // Reset state, including forcing of outputs while a divide is presented.
        #1;
        exe_div_ena = 1'b1;
        #1;
        chk("reset_outs", {25'd0, outs}, {25'd0, O_IDLE});
        chk("reset_sc", stall_cycles, 32'd0);
        do_reset();

        // Table of single-cycle load-use vectors, all from RUN.
        exp_sc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle_inputs();
            id_rs_raddr = tbl[i].rs; id_rt_raddr = tbl[i].rt;
            id_rs_used = tbl[i].rsu; id_rt_used = tbl[i].rtu;
            exe_rf_waddr = tbl[i].wa; exe_rf_wena = tbl[i].we; exe_mem_read = tbl[i].mr;
            #1;
            chk($sformatf("tbl%0d", i), {25'd0, outs}, {25'd0, tbl[i].exp});
            if (tbl[i].exp[6] == 1'b0) exp_sc++;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("tbl_sc", stall_cycles, 32'(exp_sc));

        // Load-use then the load in MEM: exactly one bubble.
        do_reset();
        @(negedge clk);
        exe_mem_read = 1'b1; exe_rf_waddr = 5'd5; exe_rf_wena = 1'b1;
        id_rs_raddr = 5'd5; id_rs_used = 1'b1;
        #1;
        chk("lu_bubble", {25'd0, outs}, {25'd0, O_LUH});
        @(negedge clk);
        idle_inputs();
        #1;
        chk("lu_after", {25'd0, outs}, {25'd0, O_IDLE});
        chk("lu_sc", stall_cycles, 32'd1);

        // Single divide: 31 frozen cycles, start pulse only on the first.
        do_reset();
        frozen = 0; pulses = 0;
        for (int c = 1; c <= DIVC; c++) begin
            @(negedge clk);
            exe_div_ena = 1'b1;
            #1;
            if (!pc_wena) frozen++;
            if (div_start) pulses++;
            if (c == 1) chk("div_first", {25'd0, outs}, {25'd0, O_DSTART});
            if (c == 2) chk("div_frozen", {25'd0, outs}, {25'd0, O_FREEZE});
            if (c == DIVC) chk("div_release", {25'd0, outs}, {25'd0, O_IDLE});
        end
        @(negedge clk);
        exe_div_ena = 1'b0;
        #1;
        chk("div_frozen_cnt", 32'(frozen), 32'(DIVC - 1));
        chk("div_pulses", 32'(pulses), 32'd1);
        chk("div_sc", stall_cycles, 32'(DIVC - 1));

        // Back-to-back divides: two pulses 32 cycles apart, 62 frozen cycles.
        do_reset();
        frozen = 0; pulses = 0; first_p = -1; second_p = -1;
        for (int c = 1; c <= 2 * DIVC; c++) begin
            @(negedge clk);
            exe_div_ena = 1'b1;
            #1;
            if (!pc_wena) frozen++;
            if (div_start) begin
                pulses++;
                if (first_p < 0) first_p = c;
                else second_p = c;
            end
        end
        @(negedge clk);
        exe_div_ena = 1'b0;
        #1;
        chk("b2b_frozen", 32'(frozen), 32'(2 * (DIVC - 1)));
        chk("b2b_pulses", 32'(pulses), 32'd2);
        chk("b2b_spacing", 32'(second_p - first_p), 32'(DIVC));
        chk("b2b_sc", stall_cycles, 32'(2 * (DIVC - 1)));

        // Reset while cnt is 10: outputs free-run immediately, count cleared.
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            exe_div_ena = 1'b1;
        end
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_outs", {25'd0, outs}, {25'd0, O_IDLE});
        chk("mid_rst_sc", stall_cycles, 32'd0);
        @(negedge clk);
        exe_div_ena = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("mid_run", {25'd0, outs}, {25'd0, O_IDLE});
        end
        chk("mid_run_sc", stall_cycles, 32'd0);

        // Multiply: frozen only when the multi-cycle multiplier is built in.
        do_reset();
        mfrozen = 0; mpulses = 0;
        for (int c = 1; c <= MULC; c++) begin
            @(negedge clk);
            exe_mul_ena = 1'b1;
            #1;
            if (!pc_wena) mfrozen++;
            if (mul_start) mpulses++;
        end
        @(negedge clk);
        exe_mul_ena = 1'b0;
        #1;
        chk("mul_frozen", 32'(mfrozen), MUL_EN ? 32'(MULC - 1) : 32'd0);
        chk("mul_pulses", 32'(mpulses), MUL_EN ? 32'd1 : 32'd0);
        chk("mul_sc", stall_cycles, MUL_EN ? 32'(MULC - 1) : 32'd0);

        // Randomized run against an occupancy-countdown model.
        do_reset();
        occ = 0; kind = 0; sc_model = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            id_rs_raddr  = 5'($urandom_range(0, 3));
            id_rt_raddr  = 5'($urandom_range(0, 3));
            id_rs_used   = 1'($urandom_range(0, 1));
            id_rt_used   = 1'($urandom_range(0, 1));
            exe_rf_waddr = 5'($urandom_range(0, 3));
            exe_rf_wena  = 1'($urandom_range(0, 3) != 0);
            exe_mem_read = 1'($urandom_range(0, 2) == 0);
            exe_div_ena  = 1'($urandom_range(0, 59) == 0);
            exe_mul_ena  = 1'($urandom_range(0, 19) == 0);
            luh_m = exe_mem_read && exe_rf_wena && exe_rf_waddr != 5'd0 &&
                    ((id_rs_used && id_rs_raddr == exe_rf_waddr) ||
                     (id_rt_used && id_rt_raddr == exe_rf_waddr));
            if (occ == 0) begin
                if (exe_div_ena) begin
                    exp_o = O_DSTART; occ = DIVC - 1;
                end else if (MUL_EN && exe_mul_ena) begin
                    exp_o = O_MSTART; occ = MULC - 1;
                end else if (luh_m) begin
                    exp_o = O_LUH;
                end else begin
                    exp_o = O_IDLE;
                end
            end else begin
                exp_o = (occ > 1) ? O_FREEZE : O_IDLE;
                occ = occ - 1;
            end
            #1;
            chk("rnd_outs", {25'd0, outs}, {25'd0, exp_o});
            chk("rnd_sc", stall_cycles, 32'(sc_model));
            if (exp_o[6] == 1'b0) sc_model++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
